da_fir_sequencer: RTL and testbench
===================================

Name: da_fir_sequencer

Overview:
- Bit-serial sequencer for the distributed-arithmetic FIR chain (first/middle/last subfilters).
- Accepts one parallel sample per valid/ready handshake and parallel-loads it into the first subfilter (x_we).
- Drives en/ts for WORD_WIDTH bit-cycles, then captures the summed subfilter result into an output register with valid/ready back-pressure.
- Sits between the sample source and the subfilter chain; one instance per filter.

Parameters:
- WORD_WIDTH, 16: sample width; also the number of bit-cycles per sample.
- SUM_WIDTH, 18: width of y_sum, the external adder-tree sum of the subfilter y outputs.
- CNT_WIDTH, $clog2(WORD_WIDTH): localparam; width of the bit counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-low.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_data  in  WORD_WIDTH  two's-complement input sample.
- x_we  out  1  parallel-load strobe to the first subfilter's shift register.
- x  out  WORD_WIDTH  parallel sample to the first subfilter; equals s_data.
- en  out  1  shift/accumulate enable to all subfilters.
- ts  out  1  sign-bit cycle flag to all subfilters (subtract-on-one).
- acc_clr  out  1  one-cycle accumulator clear to all subfilters.
- y_sum  in  SUM_WIDTH  combinational sum of the subfilter y outputs.
- m_valid  out  1  result valid.
- m_ready  in  1  result ready.
- y_out  out  SUM_WIDTH  registered filter result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, cnt=0, m_valid=0, y_out=0.
  - While rst==0: en=0, ts=0, x_we=0, acc_clr=0, s_ready=0.
  - Reset mid-operation aborts the sample in flight. Its result is never presented.
- States: IDLE, SHIFT, STALL.
- IDLE:
  - s_ready=1.
  - On s_valid (accept cycle): x_we=1 and acc_clr=1 in the same cycle; x=s_data; en=0. Next state SHIFT, cnt=0.
- SHIFT:
  - en=1, s_ready=0, cnt increments by 1 each cycle.
  - ts=1 only when cnt==WORD_WIDTH-1; ts=0 otherwise.
- Last bit-cycle (cnt==WORD_WIDTH-1), capture path: if m_valid==0 or m_ready==1, then y_out<=y_sum, m_valid<=1, next state IDLE, cnt<=0.
- Last bit-cycle, stall path: otherwise en=0 and ts=1, next state STALL. Holding en=0 freezes the subfilter registers, so y_sum stays stable.
- STALL:
  - en=0, ts=1, s_ready=0.
  - When m_ready==1 (m_valid is necessarily 1): capture as above, en=1 for that cycle, next state IDLE.
- Output handshake:
  - m_valid clears on m_valid && m_ready, unless a capture occurs in the same cycle; then m_valid stays 1 and y_out takes the new value.
  - y_out is stable while m_valid && !m_ready.
- Timing:
  - Latency from the accept cycle (cycle 0) to m_valid high: WORD_WIDTH+1 cycles (cycle 17 for W=16).
  - Throughput: one sample per WORD_WIDTH+1 cycles when m_ready is held high.
- x_we and acc_clr are never asserted together with en.
- busy=1 in SHIFT and STALL.
- cnt never exceeds WORD_WIDTH-1. No wrap occurs inside SHIFT.

Decomposition:
- Package da_pkg holds:
  - state enum da_seq_state_t {IDLE, SHIFT, STALL};
  - DA_WORD_WIDTH=16 and DA_SUM_WIDTH=18 defaults.
- Sub-module da_bit_counter:
  - ports: clk, rst, clr, inc, cnt, last;
  - last = (cnt==WORD_WIDTH-1).
- FSM and output register stay in the top module.

Test Plan:
- Single sample, W=16: s_data=16'h4000 accepted at cycle 0 with m_ready=1 → x_we=1 and acc_clr=1 at cycle 0; en=1 at cycles 1–16; ts=1 only at cycle 16; m_valid rises at cycle 17 with y_out equal to the y_sum value at cycle 16.
- Back-to-back: s_valid held with samples 16'h0001, 16'h8000, 16'h7FFF and m_ready=1 → accepts at cycles 0, 17, 34; three results in order; s_ready=0 during every SHIFT.
- Back-pressure: m_ready=0 after the first result, second sample accepted at cycle 17 → at cycle 33 en=0 and state STALL; en and ts frozen until m_ready=1 at cycle 40.
  - Cycle 40 behaviour: first result consumed and second captured in the same cycle, so m_valid stays 1 with the new y_out.
- Reset mid-SHIFT: rst=0 at cnt=7 → next cycle state IDLE, en=0, m_valid=0, y_out=0.
  - After reset: rst=1 gives s_ready=1, and a new sample completes normally 17 cycles after acceptance.
- Idle hygiene: s_valid=0 for 50 cycles → en, x_we, acc_clr and ts are all 0; busy=0; m_valid unchanged.

Source files
------------

// File: rtl/da_fir_sequencer_pkg.sv
// Shared types and default widths for the distributed-arithmetic FIR sequencer.
package da_pkg;

   localparam int DA_WORD_WIDTH = 16;
   localparam int DA_SUM_WIDTH  = 18;

   // IDLE waits for a sample, SHIFT runs the bit-cycles, STALL parks on the
   // sign-bit cycle until the output register is free.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STALL = 2'd2
   } da_seq_state_t;

endpackage

// File: rtl/da_fir_sequencer_bit_counter.sv
// Bit-cycle counter for the DA sequencer: counts shift cycles within one sample
// and flags the sign-bit (last) cycle.
module da_bit_counter
   import da_pkg::*;
#(
   parameter int WORD_WIDTH = DA_WORD_WIDTH,
   parameter int CNT_WIDTH  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 last
);

   localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(WORD_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] C_ZERO = CNT_WIDTH'(0);

   logic [CNT_WIDTH-1:0] r_cnt;

   // Counter register: clear has priority over increment; holds otherwise.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= C_ZERO;
      end else if (clr) begin
         r_cnt <= C_ZERO;
      end else if (inc) begin
         r_cnt <= r_cnt + C_ONE;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign cnt  = r_cnt;
   assign last = (r_cnt == C_LAST);

endmodule

// File: rtl/da_fir_sequencer.sv
// Bit-serial sequencer for a distributed-arithmetic FIR subfilter chain.
// Takes one sample per handshake, runs WORD_WIDTH bit-cycles on the chain,
// then registers the adder-tree sum with valid/ready back-pressure.
module da_fir_sequencer
   import da_pkg::*;
#(
   parameter int WORD_WIDTH = DA_WORD_WIDTH,
   parameter int SUM_WIDTH  = DA_SUM_WIDTH
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WORD_WIDTH-1:0] s_data,
   output logic                  x_we,
   output logic [WORD_WIDTH-1:0] x,
   output logic                  en,
   output logic                  ts,
   output logic                  acc_clr,
   input  logic [SUM_WIDTH-1:0]  y_sum,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [SUM_WIDTH-1:0]  y_out,
   output logic                  busy
);

   localparam int CNT_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

   da_seq_state_t          r_state;
   logic                   r_m_valid;
   logic [SUM_WIDTH-1:0]   r_y_out;

   // The counter value itself is only consumed through its last flag.
   logic [CNT_WIDTH-1:0]   w_cnt_unused;
   logic                   w_last;
   logic                   w_accept;
   logic                   w_capture;
   logic                   w_cnt_clr;
   logic                   w_cnt_inc;

   da_bit_counter #(
      .WORD_WIDTH (WORD_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_bit_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_cnt_clr),
      .inc  (w_cnt_inc),
      .cnt  (w_cnt_unused),
      .last (w_last)
   );

   // Chain controls and handshake decode; everything is forced low during reset.
   always_comb begin
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_cnt_clr = 1'b0;
      w_cnt_inc = 1'b0;
      s_ready   = 1'b0;
      x_we      = 1'b0;
      acc_clr   = 1'b0;
      en        = 1'b0;
      ts        = 1'b0;
      if (!rst) begin
         s_ready = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               s_ready = 1'b1;
               if (s_valid) begin
                  // Load the sample and clear accumulators; no shift this cycle.
                  w_accept  = 1'b1;
                  x_we      = 1'b1;
                  acc_clr   = 1'b1;
                  w_cnt_clr = 1'b1;
               end else begin
                  w_accept = 1'b0;
               end
            end
            SHIFT: begin
               if (w_last) begin
                  ts = 1'b1;
                  if (!r_m_valid || m_ready) begin
                     w_capture = 1'b1;
                     en        = 1'b1;
                     w_cnt_clr = 1'b1;
                  end else begin
                     // Output slot occupied: freeze the chain on the sign bit.
                     en = 1'b0;
                  end
               end else begin
                  en        = 1'b1;
                  w_cnt_inc = 1'b1;
               end
            end
            STALL: begin
               ts = 1'b1;
               if (m_ready) begin
                  w_capture = 1'b1;
                  en        = 1'b1;
                  w_cnt_clr = 1'b1;
               end else begin
                  en = 1'b0;
               end
            end
            default: begin
               s_ready = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state and registered result with valid/ready hand-off.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_m_valid <= 1'b0;
         r_y_out   <= {SUM_WIDTH{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_state <= SHIFT;
               end else begin
                  r_state <= IDLE;
               end
            end
            SHIFT: begin
               if (w_capture) begin
                  r_state <= IDLE;
               end else if (w_last) begin
                  r_state <= STALL;
               end else begin
                  r_state <= SHIFT;
               end
            end
            STALL: begin
               if (w_capture) begin
                  r_state <= IDLE;
               end else begin
                  r_state <= STALL;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // A capture in the same cycle as a consume keeps valid high.
         if (w_capture) begin
            r_m_valid <= 1'b1;
            r_y_out   <= y_sum;
         end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_y_out   <= r_y_out;
         end else begin
            r_m_valid <= r_m_valid;
            r_y_out   <= r_y_out;
         end
      end
   end

   assign x       = s_data;
   assign m_valid = r_m_valid;
   assign y_out   = r_y_out;
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_da_fir_sequencer.sv
// Self-checking bench for da_fir_sequencer: a cycle-level behavioural model
// checked every cycle, plus hand-computed expectations per directed scenario.
module tb_da_fir_sequencer;

   localparam int W  = 16;
   localparam int SW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [W-1:0]  s_data;
   logic          x_we;
   logic [W-1:0]  x;
   logic          en;
   logic          ts;
   logic          acc_clr;
   logic [SW-1:0] y_sum;
   logic          m_valid;
   logic          m_ready;
   logic [SW-1:0] y_out;
   logic          busy;

   int n_vec = 0;
   int n_err = 0;

   da_fir_sequencer #(.WORD_WIDTH(W), .SUM_WIDTH(SW)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .x_we    (x_we),
      .x       (x),
      .en      (en),
      .ts      (ts),
      .acc_clr (acc_clr),
      .y_sum   (y_sum),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .y_out   (y_out),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 = waiting for a sample, k = k-th bit-cycle (1..W),
   // W+1 = sign-bit cycle parked until the result slot frees up.
   int            mdl_phase = 0;
   logic          mdl_mv    = 1'b0;
   logic [SW-1:0] mdl_y     = '0;
   bit            mdl_live  = 1'b0;
   bit            mdl_cap;

   // Model state update at each rising edge from the inputs of the ending cycle.
   always @(posedge clk) begin
      if (!rst) begin
         mdl_phase = 0;
         mdl_mv    = 1'b0;
         mdl_y     = '0;
         mdl_live  = 1'b1;
      end else begin
         mdl_cap = ((mdl_phase == W) && (!mdl_mv || m_ready)) ||
                   ((mdl_phase == W + 1) && m_ready);
         if (mdl_cap) begin
            mdl_mv    = 1'b1;
            mdl_y     = y_sum;
            mdl_phase = 0;
         end else begin
            if (mdl_mv && m_ready) mdl_mv = 1'b0;
            if (mdl_phase == 0)            mdl_phase = s_valid ? 1 : 0;
            else if (mdl_phase < W + 1)    mdl_phase = mdl_phase + 1;
         end
      end
   end

   logic e_sr, e_xwe, e_en, e_ts;

   // Every-cycle comparison of all outputs against the model, mid-cycle.
   always @(negedge clk) begin
      if (mdl_live) begin
         e_sr = 1'b0; e_xwe = 1'b0; e_en = 1'b0; e_ts = 1'b0;
         if (rst) begin
            if (mdl_phase == 0) begin
               e_sr  = 1'b1;
               e_xwe = s_valid;
            end else if (mdl_phase < W) begin
               e_en = 1'b1;
            end else if (mdl_phase == W) begin
               e_ts = 1'b1;
               e_en = !mdl_mv || m_ready;
            end else begin
               e_ts = 1'b1;
               e_en = m_ready;
            end
         end
         chk("mdl_s_ready", 32'(s_ready), 32'(e_sr));
         chk("mdl_x_we",    32'(x_we),    32'(e_xwe));
         chk("mdl_acc_clr", 32'(acc_clr), 32'(e_xwe));
         chk("mdl_en",      32'(en),      32'(e_en));
         chk("mdl_ts",      32'(ts),      32'(e_ts));
         chk("mdl_busy",    32'(busy),    32'(mdl_phase != 0));
         chk("mdl_m_valid", 32'(m_valid), 32'(mdl_mv));
         chk("mdl_y_out",   32'(y_out),   32'(mdl_y));
         chk("mdl_x",       32'(x),       32'(s_data));
      end
   end

   // ---------------- directed stimulus ----------------
   // y_sum ramps with the scenario cycle so each capture point has a known value.
   task automatic drive(input int t, input logic r, input logic sv,
                        input logic [W-1:0] sd, input logic mr);
      rst     = r;
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      y_sum   = 18'h100 + 18'(t * 3);
   endtask

   initial begin
      rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; y_sum = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_y_out",   32'(y_out),   32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_en",      32'(en),      32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;

      // Single sample, m_ready high throughout.
      for (int t = 0; t <= 18; t++) begin
         drive(t, 1'b1, (t == 0), 16'h4000, 1'b1);
         @(negedge clk);
         chk("t1_en",      32'(en),      32'(t >= 1 && t <= 16));
         chk("t1_ts",      32'(ts),      32'(t == 16));
         chk("t1_x_we",    32'(x_we),    32'(t == 0));
         chk("t1_acc_clr", 32'(acc_clr), 32'(t == 0));
         chk("t1_m_valid", 32'(m_valid), 32'(t == 17));
         if (t == 17) chk("t1_y_out", 32'(y_out), 32'h130);
         @(posedge clk); #1;
      end

      // Back-to-back samples with s_valid held.
      for (int t = 0; t <= 52; t++) begin
         drive(t, 1'b1, (t <= 34),
               (t < 17) ? 16'h0001 : ((t < 34) ? 16'h8000 : 16'h7FFF), 1'b1);
         @(negedge clk);
         chk("t2_s_ready", 32'(s_ready), 32'(t == 0 || t == 17 || t == 34 || t >= 51));
         chk("t2_x_we",    32'(x_we),    32'(t == 0 || t == 17 || t == 34));
         chk("t2_m_valid", 32'(m_valid), 32'(t == 17 || t == 34 || t == 51));
         if (t == 17) chk("t2_y0", 32'(y_out), 32'h130);
         if (t == 34) chk("t2_y1", 32'(y_out), 32'h163);
         if (t == 51) chk("t2_y2", 32'(y_out), 32'h196);
         @(posedge clk); #1;
      end

      // Back-pressure: result slot blocked from cycle 17 to 39.
      for (int t = 0; t <= 42; t++) begin
         drive(t, 1'b1, (t <= 17), (t < 17) ? 16'h1234 : 16'hFEDC,
               (t <= 16) || (t >= 40));
         @(negedge clk);
         chk("t3_en",      32'(en),      32'((t >= 1 && t <= 16) || (t >= 18 && t <= 32) || t == 40));
         chk("t3_ts",      32'(ts),      32'(t == 16 || (t >= 33 && t <= 40)));
         chk("t3_busy",    32'(busy),    32'((t >= 1 && t <= 16) || (t >= 18 && t <= 40)));
         chk("t3_m_valid", 32'(m_valid), 32'(t >= 17 && t <= 41));
         if (t >= 17 && t <= 40) chk("t3_y_hold", 32'(y_out), 32'h130);
         if (t == 41) chk("t3_y_new", 32'(y_out), 32'h178);
         @(posedge clk); #1;
      end

      // Reset while the second sample is at bit 7, then a fresh sample.
      for (int t = 0; t <= 44; t++) begin
         drive(t, (t != 25), (t <= 17) || (t == 26),
               (t < 17) ? 16'h00FF : ((t < 26) ? 16'h5555 : 16'hAAAA),
               (t >= 26 && t <= 42));
         @(negedge clk);
         if (t == 25) begin
            chk("t4_pre_m_valid", 32'(m_valid), 32'd1);
            chk("t4_pre_y",       32'(y_out),   32'h130);
            chk("t4_rst_en",      32'(en),      32'd0);
         end
         if (t == 26) begin
            chk("t4_m_valid", 32'(m_valid), 32'd0);
            chk("t4_y_out",   32'(y_out),   32'd0);
            chk("t4_s_ready", 32'(s_ready), 32'd1);
            chk("t4_busy",    32'(busy),    32'd0);
            chk("t4_x_we",    32'(x_we),    32'd1);
         end
         if (t == 42) chk("t4_m_valid_early", 32'(m_valid), 32'd0);
         if (t >= 43) begin
            chk("t4_m_valid_new", 32'(m_valid), 32'd1);
            chk("t4_y_new",       32'(y_out),   32'h17E);
         end
         @(posedge clk); #1;
      end

      // Idle hygiene with a result parked in the output register.
      for (int t = 0; t < 50; t++) begin
         drive(t, 1'b1, 1'b0, 16'hFFFF, 1'b0);
         @(negedge clk);
         chk("t5_en",      32'(en),      32'd0);
         chk("t5_ts",      32'(ts),      32'd0);
         chk("t5_x_we",    32'(x_we),    32'd0);
         chk("t5_acc_clr", 32'(acc_clr), 32'd0);
         chk("t5_busy",    32'(busy),    32'd0);
         chk("t5_m_valid", 32'(m_valid), 32'd1);
         chk("t5_y_out",   32'(y_out),   32'h17E);
         @(posedge clk); #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
